// File: rtl/fg_pkg.sv
// Shared types and default widths for the
// function-generator period sequencer.
package fg_pkg;

  localparam int FG_COUNTER_BW   = 32;
  localparam int FG_WAVEFORM_BW  = 16;
  localparam int FG_PRESCALER_BW = 16;
  localparam int FG_BURST_BW     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fg_period_sequencer_if.sv
// Host-side control and configuration bundle
// of the period sequencer.
interface fg_period_sequencer_if
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH   = FG_COUNTER_BW,
  parameter int WAVEFORM_BITWIDTH  = FG_WAVEFORM_BW,
  parameter int PRESCALER_BITWIDTH = FG_PRESCALER_BW,
  parameter int BURST_BITWIDTH     = FG_BURST_BW
);

  logic                          start_i;
  logic                          stop_i;
  logic                          burst_en_i;
  logic [BURST_BITWIDTH-1:0]     burst_count_i;
  logic                          commit_i;
  logic [PRESCALER_BITWIDTH-1:0] prescaler_i;
  logic [COUNTER_BITWIDTH-1:0]   counter_i;
  logic [COUNTER_BITWIDTH-1:0]   ON_counter_i;
  logic [WAVEFORM_BITWIDTH-1:0]  k_rise_i;
  logic [WAVEFORM_BITWIDTH-1:0]  k_fall_i;
  logic [WAVEFORM_BITWIDTH-1:0]  amplitude_i;
  logic                          commit_ack_o;
  logic                          busy_o;

  modport master (
    output start_i, stop_i, burst_en_i,
    output burst_count_i, commit_i,
    output prescaler_i, counter_i,
    output ON_counter_i, k_rise_i,
    output k_fall_i, amplitude_i,
    input  commit_ack_o, busy_o
  );

  modport slave (
    input  start_i, stop_i, burst_en_i,
    input  burst_count_i, commit_i,
    input  prescaler_i, counter_i,
    input  ON_counter_i, k_rise_i,
    input  k_fall_i, amplitude_i,
    output commit_ack_o, busy_o
  );

endinterface

// File: rtl/fg_prescaler.sv
// Step prescaler: ticks once every div_i+1
// clocks while running, held at 0 otherwise.
module fg_prescaler
  import fg_pkg::*;
#(
  parameter int WIDTH = FG_PRESCALER_BW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt;

  // >= keeps the count bounded if div_i
  // shrinks at a period boundary
  assign tick_o = run_i && (cnt >= div_i);

  // count up, restart on tick or when idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (!run_i || clr_i || tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fg_period_sequencer.sv
// Period/step sequencer for the waveform
// datapath with double-buffered config.
module fg_period_sequencer
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH   = FG_COUNTER_BW,
  parameter int WAVEFORM_BITWIDTH  = FG_WAVEFORM_BW,
  parameter int PRESCALER_BITWIDTH = FG_PRESCALER_BW,
  parameter int BURST_BITWIDTH     = FG_BURST_BW
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  fg_period_sequencer_if.slave         host,
  output logic                         clk_en_o,
  output logic [COUNTER_BITWIDTH-1:0]  CR_o,
  output logic                         period_done_o,
  output logic [COUNTER_BITWIDTH-1:0]  counter_o,
  output logic [COUNTER_BITWIDTH-1:0]  ON_counter_o,
  output logic [WAVEFORM_BITWIDTH-1:0] k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0] k_fall_o,
  output logic [WAVEFORM_BITWIDTH-1:0] amplitude_o
);

  localparam int CW = COUNTER_BITWIDTH;
  localparam int WW = WAVEFORM_BITWIDTH;
  localparam int PW = PRESCALER_BITWIDTH;
  localparam int BW = BURST_BITWIDTH;

  state_t state_q;
  state_t state_d;

  logic run;
  logic go;
  logic wrap;
  logic apply;
  logic leave;
  logic tick;
  logic last_burst;
  logic ack_q;

  logic          pend_v;
  logic [CW-1:0] pend_counter;
  logic [CW-1:0] pend_on;
  logic [WW-1:0] pend_kr;
  logic [WW-1:0] pend_kf;
  logic [WW-1:0] pend_amp;
  logic [PW-1:0] pend_presc;
  logic [PW-1:0] prescaler_act;

  logic          burst_q;
  logic [BW-1:0] remain_q;

  assign run   = (state_q != ST_IDLE);
  assign go    = (state_q == ST_IDLE) &&
                 host.start_i && !host.stop_i;
  assign wrap  = clk_en_o &&
                 (CR_o == counter_o);
  assign apply = (go || wrap) && pend_v;
  assign leave = run && (state_d == ST_IDLE);

  assign last_burst = burst_q &&
                      (remain_q <= BW'(1));

  assign host.busy_o       = run;
  assign host.commit_ack_o = ack_q;

  fg_prescaler #(
    .WIDTH (PW)
  ) u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (run),
    .clr_i  (leave),
    .div_i  (prescaler_act),
    .tick_o (tick)
  );

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: stop drains to the period end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wrap && last_burst) begin
          state_d = ST_IDLE;
        end else if (host.stop_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // step pulse, period counter and event pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_en_o      <= 1'b0;
      CR_o          <= '0;
      period_done_o <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      clk_en_o      <= tick && !leave;
      period_done_o <= wrap;
      ack_q         <= apply;
      if (!run || leave) begin
        CR_o <= '0;
      end else if (clk_en_o) begin
        CR_o <= wrap ? '0 : CR_o + CW'(1);
      end
    end
  end

  // pending buffer and active set swap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_v        <= 1'b0;
      pend_counter  <= '0;
      pend_on       <= '0;
      pend_kr       <= '0;
      pend_kf       <= '0;
      pend_amp      <= '0;
      pend_presc    <= '0;
      counter_o     <= '0;
      ON_counter_o  <= '0;
      k_rise_o      <= '0;
      k_fall_o      <= '0;
      amplitude_o   <= '0;
      prescaler_act <= '0;
    end else begin
      pend_v <= host.commit_i ||
                (pend_v && !(go || wrap));
      if (host.commit_i) begin
        pend_counter <= host.counter_i;
        pend_on      <= host.ON_counter_i;
        pend_kr      <= host.k_rise_i;
        pend_kf      <= host.k_fall_i;
        pend_amp     <= host.amplitude_i;
        pend_presc   <= host.prescaler_i;
      end
      if (apply) begin
        counter_o     <= pend_counter;
        ON_counter_o  <= pend_on;
        k_rise_o      <= pend_kr;
        k_fall_o      <= pend_kf;
        amplitude_o   <= pend_amp;
        prescaler_act <= pend_presc;
      end
    end
  end

  // burst mode and remaining period count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_q  <= 1'b0;
      remain_q <= '0;
    end else if (go) begin
      burst_q  <= host.burst_en_i;
      remain_q <= (host.burst_count_i == '0) ?
                  BW'(1) : host.burst_count_i;
    end else if (wrap && burst_q &&
                 remain_q != '0) begin
      remain_q <= remain_q - BW'(1);
    end
  end

endmodule

// File: tb/tb_fg_period_sequencer.sv
// Bench for fg_period_sequencer: directed
// scenarios plus random traffic vs a model.
module tb_fg_period_sequencer;

  localparam int CW = 32;
  localparam int WW = 16;
  localparam int PW = 16;
  localparam int BW = 16;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [CW-1:0] on;
    logic [PW-1:0] presc;
    logic [WW-1:0] kr;
    logic [WW-1:0] kf;
    logic [WW-1:0] amp;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fg_period_sequencer_if #(
    .COUNTER_BITWIDTH   (CW),
    .WAVEFORM_BITWIDTH  (WW),
    .PRESCALER_BITWIDTH (PW),
    .BURST_BITWIDTH     (BW)
  ) hif ();

  logic          clk_en;
  logic          pd;
  logic [CW-1:0] cr;
  logic [CW-1:0] cnt_o;
  logic [CW-1:0] on_o;
  logic [WW-1:0] kr_o;
  logic [WW-1:0] kf_o;
  logic [WW-1:0] amp_o;

  fg_period_sequencer #(
    .COUNTER_BITWIDTH   (CW),
    .WAVEFORM_BITWIDTH  (WW),
    .PRESCALER_BITWIDTH (PW),
    .BURST_BITWIDTH     (BW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host          (hif),
    .clk_en_o      (clk_en),
    .CR_o          (cr),
    .period_done_o (pd),
    .counter_o     (cnt_o),
    .ON_counter_o  (on_o),
    .k_rise_o      (kr_o),
    .k_fall_o      (kf_o),
    .amplitude_o   (amp_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tcyc  = 0;

  // stimulus for the next clock
  logic          t_rst;
  logic          t_start;
  logic          t_stop;
  logic          t_commit;
  logic          t_burst_en;
  logic [BW-1:0] t_bc;
  cfg_t          t_live;

  // model state: expected outputs of the
  // current cycle plus bookkeeping
  int            m_mode;
  int            m_cyc;
  int            m_last;
  logic          m_en;
  logic [CW-1:0] m_cr;
  logic          m_pd;
  logic          m_ack;
  cfg_t          m_act;
  cfg_t          m_pend;
  logic          m_pend_v;
  logic          m_burst;
  int            m_left;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               nm, act, exp, tcyc);
    end
  endtask

  // one clock of the reference behaviour:
  // steps are spaced presc+1 clocks from the
  // last step (or from start), a period is
  // cnt+1 steps, config swaps on boundaries
  task automatic model_step();
    bit tk;
    bit wr;
    bit go;
    int nm;
    logic [CW-1:0] ncr;
    if (t_rst) begin
      m_mode   = 0;
      m_en     = 1'b0;
      m_cr     = '0;
      m_pd     = 1'b0;
      m_ack    = 1'b0;
      m_act    = '0;
      m_pend   = '0;
      m_pend_v = 1'b0;
      m_burst  = 1'b0;
      m_left   = 0;
      m_last   = m_cyc;
    end else begin
      tk = (m_mode != 0) &&
           ((m_cyc - m_last - 1) >= int'(m_act.presc));
      wr = m_en && (m_cr == m_act.cnt);
      go = (m_mode == 0) && t_start && !t_stop;
      nm = m_mode;
      if (go) nm = 1;
      else if (m_mode != 0 && wr &&
               (m_mode == 2 ||
                (m_burst && m_left == 1))) nm = 0;
      else if (m_mode == 1 && t_stop) nm = 2;
      if (nm == 0) ncr = '0;
      else if (m_en) ncr = wr ? '0 : m_cr + 1;
      else ncr = m_cr;
      m_pd  = wr;
      m_ack = (go || wr) && m_pend_v;
      if (m_ack) m_act = m_pend;
      if (t_commit) begin
        m_pend   = t_live;
        m_pend_v = 1'b1;
      end else if (go || wr) begin
        m_pend_v = 1'b0;
      end
      if (tk || go) m_last = m_cyc;
      if (go) begin
        m_burst = t_burst_en;
        m_left  = (t_bc == 0) ? 1 : int'(t_bc);
      end else if (wr && m_burst) begin
        m_left--;
      end
      m_en   = tk && (nm != 0);
      m_cr   = ncr;
      m_mode = nm;
    end
    m_cyc++;
  endtask

  task automatic compare();
    chk("clk_en", clk_en, m_en);
    chk("CR", cr, m_cr);
    chk("period_done", pd, m_pd);
    chk("commit_ack", hif.commit_ack_o, m_ack);
    chk("busy", hif.busy_o, m_mode != 0);
    chk("counter", cnt_o, m_act.cnt);
    chk("ON_counter", on_o, m_act.on);
    chk("k_rise", kr_o, m_act.kr);
    chk("k_fall", kf_o, m_act.kf);
    chk("amplitude", amp_o, m_act.amp);
  endtask

  // drive, advance one clock, check at negedge
  task automatic cyc();
    rst               = t_rst;
    hif.start_i       = t_start;
    hif.stop_i        = t_stop;
    hif.commit_i      = t_commit;
    hif.burst_en_i    = t_burst_en;
    hif.burst_count_i = t_bc;
    hif.counter_i     = t_live.cnt;
    hif.ON_counter_i  = t_live.on;
    hif.prescaler_i   = t_live.presc;
    hif.k_rise_i      = t_live.kr;
    hif.k_fall_i      = t_live.kf;
    hif.amplitude_i   = t_live.amp;
    model_step();
    @(negedge clk);
    compare();
    t_start  = 1'b0;
    t_stop   = 1'b0;
    t_commit = 1'b0;
    tcyc++;
  endtask

  task automatic set_cfg(input int c, input int p);
    t_live.cnt   = CW'(c);
    t_live.presc = PW'(p);
    t_live.on    = 32'($urandom);
    t_live.kr    = 16'($urandom);
    t_live.kf    = 16'($urandom);
    t_live.amp   = 16'($urandom);
  endtask

  task automatic do_reset();
    t_rst = 1'b1;
    cyc();
    t_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    int crs[$];
    int pdt[$];
    int exp_cr[5];
    int t0;
    int first;
    int maxcr;
    int n_en;
    int n_pd;
    int n_ack;
    exp_cr = '{0, 1, 2, 3, 0};
    t_rst = 1'b0; t_start = 1'b0;
    t_stop = 1'b0; t_commit = 1'b0;
    t_burst_en = 1'b0; t_bc = '0;
    t_live = '0;
    m_cyc = 0;
    do_reset();
    chk("rst_cr", cr, 0);
    chk("rst_busy", hif.busy_o, 0);

    // continuous run, counter 3, prescaler 1
    set_cfg(3, 1);
    t_commit = 1'b1;
    cyc();
    t_start = 1'b1;
    cyc();
    t0 = tcyc - 1;
    chk("t2_ack", hif.commit_ack_o, 1);
    chk("t2_cnt", cnt_o, 3);
    first = -1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (clk_en) begin
        crs.push_back(int'(cr));
        if (first < 0) first = tcyc;
      end
      if (pd) pdt.push_back(tcyc);
    end
    chk("t2_first_lat", first - t0, 3);
    chk("t2_npulse", crs.size() >= 5, 1);
    for (int i = 0; i < 5 && i < crs.size(); i++)
      chk("t2_cr_seq", crs[i], exp_cr[i]);
    chk("t2_npd", pdt.size(), 3);
    if (pdt.size() >= 2)
      chk("t2_pd_gap", pdt[1] - pdt[0], 8);

    // commit mid-period waits for the wrap
    for (int i = 0; i < 40 && cr != 1; i++)
      cyc();
    chk("t3_reach", cr, 1);
    set_cfg(5, 1);
    t_commit = 1'b1;
    cyc();
    chk("t3_hold", cnt_o, 3);
    for (int i = 0; i < 40 &&
         !hif.commit_ack_o; i++)
      cyc();
    chk("t3_ack", hif.commit_ack_o, 1);
    chk("t3_ack_pd", pd, 1);
    chk("t3_cnt_new", cnt_o, 5);
    maxcr = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (int'(cr) > maxcr) maxcr = int'(cr);
    end
    chk("t3_max", maxcr, 5);

    // reset mid-run drops the pending set
    do_reset();
    set_cfg(7, 0);
    t_commit = 1'b1;
    cyc();
    t_start = 1'b1;
    cyc();
    set_cfg(2, 0);
    t_commit = 1'b1;
    cyc();
    for (int i = 0; i < 20 && cr != 5; i++)
      cyc();
    chk("t1_reach", cr, 5);
    rst = 1'b1;
    #1;
    chk("t1_async_cr", cr, 0);
    chk("t1_async_en", clk_en, 0);
    chk("t1_async_busy", hif.busy_o, 0);
    chk("t1_async_cnt", cnt_o, 0);
    do_reset();
    t_start = 1'b1;
    cyc();
    chk("t1_noack", hif.commit_ack_o, 0);

    // stop drains to the period end
    do_reset();
    set_cfg(3, 0);
    t_commit = 1'b1;
    cyc();
    t_start = 1'b1;
    cyc();
    for (int i = 0; i < 20 && cr != 1; i++)
      cyc();
    chk("t5_reach", cr, 1);
    t_stop = 1'b1;
    cyc();
    chk("t5_drain_busy", hif.busy_o, 1);
    t_stop = 1'b1;
    cyc();
    maxcr = int'(cr);
    for (int i = 0; i < 20 && hif.busy_o; i++) begin
      cyc();
      if (int'(cr) > maxcr) maxcr = int'(cr);
    end
    chk("t5_idle", hif.busy_o, 0);
    chk("t5_max", maxcr, 3);
    chk("t5_cr0", cr, 0);
    t_start = 1'b1;
    t_stop  = 1'b1;
    cyc();
    chk("t5_startstop", hif.busy_o, 0);

    // burst of 2 periods, then burst count 0
    do_reset();
    set_cfg(2, 0);
    t_commit = 1'b1;
    cyc();
    t_burst_en = 1'b1;
    t_bc = 16'd2;
    t_start = 1'b1;
    cyc();
    n_en = 0; n_pd = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_en += int'(clk_en);
      n_pd += int'(pd);
    end
    chk("t4_pulses", n_en, 6);
    chk("t4_pds", n_pd, 2);
    chk("t4_idle", hif.busy_o, 0);
    chk("t4_cr0", cr, 0);
    t_bc = 16'd0;
    t_start = 1'b1;
    cyc();
    n_en = 0; n_pd = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_en += int'(clk_en);
      n_pd += int'(pd);
    end
    chk("t4_bc0_pulses", n_en, 3);
    chk("t4_bc0_pds", n_pd, 1);
    t_burst_en = 1'b0;

    // commit on the wrap with A pending
    do_reset();
    set_cfg(1, 0);
    t_commit = 1'b1;
    cyc();
    t_start = 1'b1;
    cyc();
    set_cfg(2, 0);
    t_commit = 1'b1;
    cyc();
    for (int i = 0; i < 20 &&
         !(clk_en && cr == cnt_o); i++)
      cyc();
    chk("t6_wrap", clk_en && cr == cnt_o, 1);
    set_cfg(3, 0);
    t_commit = 1'b1;
    cyc();
    chk("t6_ackA", hif.commit_ack_o, 1);
    chk("t6_cntA", cnt_o, 2);
    n_ack = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_ack += int'(hif.commit_ack_o);
    end
    chk("t6_nack", n_ack, 2);
    chk("t6_cntB", cnt_o, 3);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      t_rst      = ($urandom_range(0, 499) == 0);
      t_start    = ($urandom_range(0, 19) == 0);
      t_stop     = ($urandom_range(0, 39) == 0);
      t_commit   = ($urandom_range(0, 14) == 0);
      t_burst_en = 1'($urandom_range(0, 1));
      t_bc       = BW'($urandom_range(0, 3));
      set_cfg($urandom_range(0, 6),
              $urandom_range(0, 3));
      cyc();
    end
    t_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
